// File: rtl/regfile_param.sv
// Purpose : parametrised 2-read/1-write register file with hardwired-zero, bypass and clear engine.
// Latency : reads are combinational; writes commit on the rising clock edge.
// Backpres: none; ready=0 while the clear engine runs, and writes are ignored then.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   reg_wre, reg_dst        - write enable; destination select (0 = rt, 1 = rd)
//   rs, rt, rd              - read port 1 addr; read port 2 / write addr; alt write addr
//   write_data              - data written to entry[reg_dst ? rd : rt]
//   clear_req               - one-cycle pulse: zero the whole array (honoured in RUN only)
//   read_data1, read_data2  - combinational data for rs / rt
//   ready                   - array valid and accepting writes
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_wre,
  input  logic              reg_dst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clear_req,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_rin;
  logic              w_rin_zero;
  logic              w_wr_en;
  logic              w_run;

  assign w_rin      = reg_dst ? rd : rt;
  assign w_run      = (r_state == ST_RUN);
  // Writes to the hardwired-zero entry are dropped; this also keeps the
  // bypass path from leaking write_data onto a read of address 0.
  assign w_rin_zero = (ZERO_REG != 0) && (w_rin == '0);
  assign w_wr_en    = w_run && reg_wre && !w_rin_zero;
  assign ready      = w_run;

  // State register and clear counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next-state logic. The counter wraps back to 0 only on the CLEAR -> RUN
  // exit (DEPTH-1 + 1 overflows), so RUN always holds clr_idx at 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  // Storage array has no reset; the clear engine initialises it. A write
  // alongside clear_req lands here and is overwritten later by the clear.
  always_ff @(posedge clock) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_rin] <= write_data;
    end
  end

  // Read ports: zero while clearing, then hardwired-zero, then bypass, then array.
  always_comb begin
    read_data1 = r_mem[rs];
    if (!w_run) begin
      read_data1 = '0;
    end else if ((ZERO_REG != 0) && (rs == '0)) begin
      read_data1 = '0;
    end else if ((BYPASS != 0) && w_wr_en && (w_rin == rs)) begin
      read_data1 = write_data;
    end
  end

  always_comb begin
    read_data2 = r_mem[rt];
    if (!w_run) begin
      read_data2 = '0;
    end else if ((ZERO_REG != 0) && (rt == '0)) begin
      read_data2 = '0;
    end else if ((BYPASS != 0) && w_wr_en && (w_rin == rt)) begin
      read_data2 = write_data;
    end
  end

endmodule
